// File: rtl/aes_spi_pkg.sv
// Shared types and sizing helpers for the AES SPI responder.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_MSG,
        RX_KEY,
        CRYPT,
        WAIT_RD,
        TX,
        DONE
    } state_t;

    localparam int MSG_BITS = 128;

    function automatic int key_bits(input int nk);
        return nk * 32;
    endfunction

    // One spare bit so the TX phase can count up to MSG_BITS itself.
    function automatic int cnt_width(input int nk);
        int longest;
        longest = (key_bits(nk) > MSG_BITS) ? key_bits(nk) : MSG_BITS;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/aes_spi_shreg.sv
// LSB-first shift register with parallel load; serial output is bit 0.
module aes_spi_shreg
    import aes_spi_pkg::*;
#(
    parameter int WIDTH = MSG_BITS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    input  logic             ser_in,
    output logic             ser_out
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {ser_in, q[WIDTH-1:1]};
        end
    end

    assign ser_out = q[0];

endmodule

// File: rtl/aes_spi_responder.sv
// SPI-side responder: deserialises message and key, hands them to the AES
// core, and serialises the core result back on MISO when asked.
//
// state   | meaning
// IDLE    | waiting for cs_n=0 with mode=0; first message bit captured here
// RX_MSG  | shifting in message bits 1..127
// RX_KEY  | shifting in key bits 0..NK*32-1
// CRYPT   | core_start pulsed on entry; waiting for core_done
// WAIT_RD | result held; waiting for mode=1 to start read-back
// TX      | driving result bits 1..127 on miso
// DONE    | read-back finished; waiting for cs_n=1
module aes_spi_responder
    import aes_spi_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cs_n,
    input  logic                      mosi,
    input  logic                      mode,
    output logic                      miso,
    output logic                      core_start,
    output logic [MSG_BITS-1:0]       core_msg,
    output logic [key_bits(NK)-1:0]   core_key,
    input  logic                      core_done,
    input  logic [MSG_BITS-1:0]       core_result,
    output logic                      busy,
    output logic                      frame_err
);

    localparam int KEY_BITS = key_bits(NK);
    localparam int CNT_W    = cnt_width(NK);
    localparam int MIDX_W   = $clog2(MSG_BITS);
    localparam int KIDX_W   = $clog2(KEY_BITS);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BITS - 1);
    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] TX_END   = CNT_W'(MSG_BITS);

    // NR only travels to the core; it is checked here against NK for sanity.
    if (!(NK == 4 || NK == 6 || NK == 8) || NR != NK + 6) begin : g_bad_cfg
        $error("aes_spi_responder: unsupported NK/NR combination");
    end

    state_t           state, next_state;
    logic [CNT_W-1:0] count, cnt_next;
    logic             msg_wr, key_wr;
    logic             tx_load, tx_shift, tx_bit;
    logic             miso_next, start_next, err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            core_msg   <= '0;
            core_key   <= '0;
            miso       <= 1'b0;
            core_start <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= next_state;
            count      <= cnt_next;
            miso       <= miso_next;
            core_start <= start_next;
            frame_err  <= err_next;
            if (msg_wr) begin
                core_msg[count[MIDX_W-1:0]] <= mosi;
            end
            if (key_wr) begin
                core_key[count[KIDX_W-1:0]] <= mosi;
            end
        end
    end

    // Every path back to IDLE clears the counter, so IDLE writes msg bit 0.
    always_comb begin
        next_state = state;
        cnt_next   = count;
        msg_wr     = 1'b0;
        key_wr     = 1'b0;
        tx_load    = 1'b0;
        tx_shift   = 1'b0;
        miso_next  = 1'b0;
        start_next = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (!cs_n && !mode) begin
                    msg_wr     = 1'b1;
                    cnt_next   = CNT_ONE;
                    next_state = RX_MSG;
                end
            end
            RX_MSG: begin
                if (cs_n) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    next_state = IDLE;
                end else begin
                    msg_wr = 1'b1;
                    if (count == MSG_LAST) begin
                        cnt_next   = '0;
                        next_state = RX_KEY;
                    end else begin
                        cnt_next = count + CNT_ONE;
                    end
                end
            end
            RX_KEY: begin
                if (cs_n) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    next_state = IDLE;
                end else begin
                    key_wr = 1'b1;
                    if (count == KEY_LAST) begin
                        cnt_next   = '0;
                        start_next = 1'b1;
                        next_state = CRYPT;
                    end else begin
                        cnt_next = count + CNT_ONE;
                    end
                end
            end
            CRYPT: begin
                // A done coinciding with our own start pulse cannot be a real result.
                if (core_done && !core_start) begin
                    tx_load    = 1'b1;
                    next_state = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (mode) begin
                    miso_next  = tx_bit;
                    tx_shift   = 1'b1;
                    cnt_next   = CNT_ONE;
                    next_state = TX;
                end
            end
            TX: begin
                if (cs_n) begin
                    err_next   = 1'b1;
                    cnt_next   = '0;
                    next_state = IDLE;
                end else if (count == TX_END) begin
                    next_state = DONE;
                end else begin
                    miso_next = tx_bit;
                    tx_shift  = 1'b1;
                    cnt_next  = count + CNT_ONE;
                end
            end
            DONE: begin
                if (cs_n) begin
                    cnt_next   = '0;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    aes_spi_shreg #(
        .WIDTH(MSG_BITS)
    ) u_tx_shreg (
        .clk      (clk),
        .reset    (reset),
        .load_en  (tx_load),
        .load_data(core_result),
        .shift_en (tx_shift),
        .ser_in   (1'b0),
        .ser_out  (tx_bit)
    );

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_aes_spi_responder.sv
// Scoreboard bench for aes_spi_responder: an NK=4 and an NK=8 instance share
// the link pins, with sel8 choosing which one is currently being exercised.
module tb_aes_spi_responder;

    localparam logic [127:0] FIPS_M = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_K = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_C = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, cs_n, mosi, mode, sel8;
    logic cs_n4, cs_n8;
    logic core_done, done4, done8;
    logic [127:0] core_result;

    logic         miso4, start4, busy4, err4;
    logic [127:0] msg4, key4;
    logic         miso8, start8, busy8, err8;
    logic [127:0] msg8;
    logic [255:0] key8;

    assign cs_n4 = cs_n | sel8;
    assign cs_n8 = cs_n | ~sel8;
    assign done4 = core_done & ~sel8;
    assign done8 = core_done & sel8;

    aes_spi_responder #(.NK(4), .NR(10)) u_dut4 (
        .clk(clk), .reset(reset), .cs_n(cs_n4), .mosi(mosi), .mode(mode),
        .miso(miso4), .core_start(start4), .core_msg(msg4), .core_key(key4),
        .core_done(done4), .core_result(core_result), .busy(busy4), .frame_err(err4)
    );

    aes_spi_responder #(.NK(8), .NR(14)) u_dut8 (
        .clk(clk), .reset(reset), .cs_n(cs_n8), .mosi(mosi), .mode(mode),
        .miso(miso8), .core_start(start8), .core_msg(msg8), .core_key(key8),
        .core_done(done8), .core_result(core_result), .busy(busy8), .frame_err(err8)
    );

    logic         cur_miso, cur_start, cur_busy, cur_err;
    logic [127:0] cur_msg;
    logic [255:0] cur_key;
    assign cur_miso  = sel8 ? miso8  : miso4;
    assign cur_start = sel8 ? start8 : start4;
    assign cur_busy  = sel8 ? busy8  : busy4;
    assign cur_err   = sel8 ? err8   : err4;
    assign cur_msg   = sel8 ? msg8   : msg4;
    assign cur_key   = sel8 ? key8   : {128'b0, key4};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [127:0] m;
        logic [255:0] k;
        int           t;
    } start_rec_t;
    typedef struct {
        logic [127:0] res;
        int           f;
        int           nbits;
    } rd_rec_t;

    start_rec_t start_q[$];
    rd_rec_t    rd_q[$];

    int           cm_delay = 20;
    bit           cm_glitch = 1'b0;
    int           done_p = 0;
    logic [127:0] exp_res;

    // Stand-in for the AES core: the real cipher for the FIPS-197 vector,
    // a cheap keyed scramble for everything else.
    function automatic logic [127:0] core_fn(input logic [127:0] m, input logic [255:0] k);
        if (m == FIPS_M && k == {128'b0, FIPS_K}) return FIPS_C;
        return {m[63:0], m[127:64]} ^ k[127:0] ^ k[255:128] ^ 128'hc3a5_5a3c_0ff0_f00f_1234_8765_abcd_dcba;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_bit({tag, "_miso"}, cur_miso, 1'b0);
        chk_bit({tag, "_start"}, cur_start, 1'b0);
        chk_vec({tag, "_msg"}, {128'b0, cur_msg}, 256'b0);
        chk_vec({tag, "_key"}, cur_key, 256'b0);
        chk_bit({tag, "_busy"}, cur_busy, 1'b0);
        chk_bit({tag, "_err"}, cur_err, 1'b0);
    endtask

    // Core model: reacts to the start pulse, optionally fires a bogus done in
    // the same cycle, then returns the real result cm_delay cycles later.
    initial begin
        logic [127:0] hm;
        logic [255:0] hk;
        int cnt;
        core_done = 1'b0;
        core_result = '0;
        hm = '0;
        hk = '0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (reset) begin
                cnt = 0;
            end else if (cur_start) begin
                hm = cur_msg;
                hk = cur_key;
                cnt = cm_delay;
                if (cm_glitch) begin
                    core_done = 1'b1;
                    core_result = ~core_fn(cur_msg, cur_key);
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_result = core_fn(hm, hk);
                    done_p = cyc + 1;
                end
            end
        end
    end

    // Start monitor: each core_start must match a queued frame.
    initial begin
        start_rec_t r;
        forever begin
            @(negedge clk);
            if (cur_start === 1'b1) begin
                if (start_q.size() == 0) begin
                    chk_bit("start_unexpected", cur_start, 1'b0);
                end else begin
                    r = start_q.pop_front();
                    chk_int("start_cycle", cyc, r.t);
                    chk_vec("core_msg", {128'b0, cur_msg}, {128'b0, r.m});
                    chk_vec("core_key", cur_key, r.k);
                end
            end
        end
    end

    // MISO monitor: collects a read-back stream at its expected first cycle,
    // otherwise requires miso to be quiet.
    initial begin
        rd_rec_t r;
        logic [127:0] got, mask;
        forever begin
            @(negedge clk);
            if (rd_q.size() > 0 && cyc == rd_q[0].f) begin
                r = rd_q.pop_front();
                got = '0;
                mask = '0;
                for (int k = 0; k < r.nbits; k++) begin
                    got[k] = cur_miso;
                    mask[k] = 1'b1;
                    if (k < r.nbits - 1) @(negedge clk);
                end
                if (r.nbits == 128) begin
                    chk_vec("miso_data", {128'b0, got}, {128'b0, r.res});
                    @(negedge clk);
                    chk_bit("miso_after", cur_miso, 1'b0);
                end else begin
                    chk_vec("miso_partial", {128'b0, got & mask}, {128'b0, r.res & mask});
                end
            end else begin
                chk_bit("miso_idle", cur_miso, 1'b0);
            end
        end
    end

    task automatic send_frame(input logic [127:0] m, input logic [255:0] k, input int abort_at);
        int kb;
        start_rec_t r;
        kb = sel8 ? 256 : 128;
        done_p = 0;
        exp_res = core_fn(m, k);
        for (int i = 0; i < 128 + kb; i++) begin
            if (i == abort_at) break;
            cs_n = 1'b0;
            mosi = (i < 128) ? m[i] : k[i-128];
            mode = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            if (i == 0 && abort_at < 0) begin
                r.m = m;
                r.k = k;
                r.t = cyc + 128 + kb;
                start_q.push_back(r);
            end
            @(negedge clk);
            if (i == 0) chk_bit("busy_rx", cur_busy, 1'b1);
        end
        if (abort_at >= 0) begin
            cs_n = 1'b1;
            mode = 1'b0;
            @(negedge clk);
            chk_bit("abort_err", cur_err, 1'b1);
            chk_bit("abort_idle", cur_busy, 1'b0);
            @(negedge clk);
            chk_bit("abort_err_pulse", cur_err, 1'b0);
        end
    endtask

    task automatic run_read(input bit early, input bit cs_hi, input int nbits);
        int n, f, c2, last;
        rd_rec_t r;
        mode = early;
        cs_n = cs_hi;
        n = 0;
        while (done_p == 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_p == 0) begin
            errors++;
            $display("FAIL done_timeout: got no core_done expected one within 400 cycles");
            cs_n = 1'b1;
            mode = 1'b0;
            return;
        end
        cs_n = 1'b0;
        if (early) begin
            f = done_p + 1;
        end else begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            mode = 1'b1;
            c2 = cyc;
            f = (done_p + 1 > c2 + 1) ? done_p + 1 : c2 + 1;
        end
        r.res = exp_res;
        r.f = f;
        r.nbits = nbits;
        rd_q.push_back(r);
        last = (nbits == 128) ? f + 128 : f + nbits - 1;
        n = 0;
        while (cyc < last && n < 1000) begin
            @(negedge clk);
            n++;
            if (cyc >= f) mode = 1'($urandom_range(0, 1));
        end
        if (nbits == 128) begin
            cs_n = 1'b1;
            @(negedge clk);
            chk_bit("done_to_idle", cur_busy, 1'b0);
            chk_bit("done_no_err", cur_err, 1'b0);
            mode = 1'b0;
        end else begin
            reset = 1'b1;
            @(negedge clk);
            chk_reset_outputs("midtx_reset");
            reset = 1'b0;
            cs_n = 1'b1;
            mode = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cs_n = 1'b1;
        mosi = 1'b0;
        mode = 1'b0;
        sel8 = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        cm_delay = 20;
        send_frame(FIPS_M, {128'b0, FIPS_K}, -1);
        run_read(1'b0, 1'b0, 128);

        send_frame(rand128(), {128'b0, rand128()}, 60);
        send_frame(rand128(), {128'b0, rand128()}, -1);
        run_read(1'b0, 1'b0, 128);

        cm_delay = 50;
        send_frame(rand128(), {128'b0, rand128()}, -1);
        run_read(1'b1, 1'b0, 128);

        cm_glitch = 1'b1;
        cm_delay = $urandom_range(2, 10);
        send_frame(rand128(), {128'b0, rand128()}, -1);
        run_read(1'b0, 1'b0, 128);
        cm_glitch = 1'b0;

        cm_delay = 15;
        send_frame(rand128(), {128'b0, rand128()}, -1);
        run_read(1'b0, 1'b1, 128);

        for (int i = 0; i < 3; i++) begin
            cm_delay = $urandom_range(1, 30);
            send_frame(rand128(), {128'b0, rand128()}, -1);
            run_read(1'b0, 1'($urandom_range(0, 1)), 128);
        end

        cm_delay = 10;
        send_frame(rand128(), {128'b0, rand128()}, -1);
        run_read(1'b0, 1'b0, 40);

        sel8 = 1'b1;
        @(negedge clk);
        cm_delay = 12;
        send_frame(rand128(), {rand128(), rand128()}, -1);
        run_read(1'b0, 1'b0, 128);

        repeat (5) @(negedge clk);
        chk_int("start_q_drained", start_q.size(), 0);
        chk_int("rd_q_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
